// File: rtl/ex_mdu.sv
// rtl/ex_mdu.sv - multi-cycle multiply/divide unit holding the HI/LO registers
//
// Ports:
//   clk      - single clock, all state updates on its rising edge
//   reset    - asynchronous, active-high reset
//   start    - qualifies mdu_op for one cycle
//   mdu_op   - 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO,
//              7 MTHI, 8 MTLO, 9 MADD, 10 MADDU, 11..15 no-op
//   rs_val   - forwarded rs operand
//   rt_val   - forwarded rt operand
//   busy     - stall request to hazard control
//   hi, lo   - architectural HI/LO registers
//   mdu_out  - hi for MFHI, lo for MFLO, else 0 (combinational)
//
// Optional feature: define MDU_MADD_EN to enable MADD/MADDU (ops 9/10).
module ex_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [63:0] res, res_nxt;
  logic [31:0] hi_nxt, lo_nxt;

  logic        is_mul_op, is_div_op;
  logic        mul_signed, div_signed;
  logic signed [63:0] prod_s;
  logic [63:0] prod_u, prod, mul_res;
  logic        rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag, q_mag, r_mag, quot, rem;
  logic [63:0] div_res;

  assign is_div_op  = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);
  assign mul_signed = (mdu_op == OP_MULT) || (mdu_op == OP_MADD);
  assign div_signed = (mdu_op == OP_DIV);

  // Multiplier: both signed and unsigned 64-bit products, selected by op.
  assign prod_s  = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign prod_u  = {32'd0, rs_val} * {32'd0, rt_val};
  assign prod    = mul_signed ? $unsigned(prod_s) : prod_u;

`ifdef MDU_MADD_EN
  // Accumulate into the HI/LO value present at the start edge.
  assign is_mul_op = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU) ||
                     (mdu_op == OP_MADD) || (mdu_op == OP_MADDU);
  assign mul_res   = ((mdu_op == OP_MADD) || (mdu_op == OP_MADDU)) ? ({hi, lo} + prod) : prod;
`else
  assign is_mul_op = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
  assign mul_res   = prod;
`endif

  // Signed divide via magnitudes: quotient truncates toward zero and the
  // remainder takes the dividend's sign. 0x8000_0000 / -1 falls out as
  // quotient 0x8000_0000, remainder 0 because the negation wraps.
  assign rs_neg  = div_signed & rs_val[31];
  assign rt_neg  = div_signed & rt_val[31];
  assign rs_mag  = rs_neg ? (32'd0 - rs_val) : rs_val;
  assign rt_mag  = rt_neg ? (32'd0 - rt_val) : rt_val;
  assign q_mag   = rs_mag / rt_mag;
  assign r_mag   = rs_mag % rt_mag;
  assign quot    = (rs_neg ^ rt_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem     = rs_neg ? (32'd0 - r_mag) : r_mag;
  assign div_res = (rt_val == 32'd0) ? {rs_val, 32'hFFFF_FFFF} : {rem, quot};

  // The issuing cycle already stalls, before the FSM has left IDLE.
  assign busy = (state == RUN) || (start && (is_mul_op || is_div_op));

  always_comb begin
    mdu_out = 32'd0;
    if (mdu_op == OP_MFHI)      mdu_out = hi;
    else if (mdu_op == OP_MFLO) mdu_out = lo;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    res_nxt   = res;
    hi_nxt    = hi;
    lo_nxt    = lo;
    if (state == IDLE) begin
      if (start) begin
        if (is_mul_op) begin
          state_nxt = RUN;
          cnt_nxt   = 4'(MULT_CYCLES);
          res_nxt   = mul_res;
        end else if (is_div_op) begin
          state_nxt = RUN;
          cnt_nxt   = 4'(DIV_CYCLES);
          res_nxt   = div_res;
        end else if (mdu_op == OP_MTHI) begin
          hi_nxt = rs_val;
        end else if (mdu_op == OP_MTLO) begin
          lo_nxt = rs_val;
        end
      end
    end else begin
      // Starts arriving in RUN are ignored; upstream is stalled by busy.
      cnt_nxt = cnt - 4'd1;
      if (cnt == 4'd1) begin
        state_nxt = IDLE;
        hi_nxt    = res[63:32];
        lo_nxt    = res[31:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      res   <= 64'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      res   <= res_nxt;
      hi    <= hi_nxt;
      lo    <= lo_nxt;
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// tb/tb_ex_mdu.sv - randomized self-checking bench for ex_mdu
module tb_ex_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdu_out;

  int          n_checks = 0;
  int          n_errs   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  ex_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mdu_op  (mdu_op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .mdu_out (mdu_out)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit madd_on();
`ifdef MDU_MADD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Number of cycles busy should be seen high for an op issued from IDLE.
  function automatic int exp_busy(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd2) return MC + 1;
    if (op == 4'd3 || op == 4'd4) return DC + 1;
    if ((op == 4'd9 || op == 4'd10) && madd_on()) return MC + 1;
    return 0;
  endfunction

  // Architectural effect of one accepted instruction on HI/LO.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa = a;
    sb = b;
    sp = longint'(sa) * longint'(sb);
    up = {32'd0, a} * {32'd0, b};
    case (op)
      4'd1: {m_hi, m_lo} = sp;
      4'd2: {m_hi, m_lo} = up;
      4'd3: begin
        if (b == 32'd0) begin
          m_hi = a; m_lo = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_hi = 32'd0; m_lo = 32'h8000_0000;
        end else begin
          m_lo = sa / sb; m_hi = sa % sb;
        end
      end
      4'd4: begin
        if (b == 32'd0) begin
          m_hi = a; m_lo = 32'hFFFF_FFFF;
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
      end
      4'd7: m_hi = a;
      4'd8: m_lo = a;
      4'd9:  if (madd_on()) {m_hi, m_lo} = {m_hi, m_lo} + sp;
      4'd10: if (madd_on()) {m_hi, m_lo} = {m_hi, m_lo} + up;
      default: ;
    endcase
  endtask

  // Called at posedge+1. Issues op, optionally injects a second start in
  // RUN cycle inj_cyc (which must be ignored), counts busy cycles, checks.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int inj_cyc, input logic [3:0] inj_op, input logic [31:0] inj_a,
                       input string tag);
    int          n;
    int          cyc;
    bit          b_s;
    logic [31:0] old_hi, old_lo, exp_out;
    old_hi = m_hi;
    old_lo = m_lo;
    start = 1'b1; mdu_op = op; rs_val = a; rt_val = b;
    n = 0; cyc = 0;
    do begin
      if (cyc > 0 && cyc == inj_cyc) begin
        start = 1'b1; mdu_op = inj_op; rs_val = inj_a; rt_val = $urandom;
      end
      #1;
      b_s = busy;
      if (b_s) n++;
      if (start) begin
        exp_out = (mdu_op == 4'd5) ? old_hi : (mdu_op == 4'd6) ? old_lo : 32'd0;
        check({tag, " mdu_out"}, mdu_out, exp_out);
      end
      @(posedge clk); #1;
      start = 1'b0; mdu_op = 4'd0;
      cyc++;
    end while (b_s && cyc < 40);
    model(op, a, b);
    check({tag, " busy_cycles"}, n, exp_busy(op));
    check({tag, " hi"}, hi, m_hi);
    check({tag, " lo"}, lo, m_lo);
  endtask

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0]  op, iop;
    logic [31:0] a, b;
    int          ic;
    reset = 1'b1; start = 1'b0; mdu_op = 4'd0; rs_val = 32'd0; rt_val = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    mdu_op = 4'd5;
    #1;
    check("reset busy", busy, 1'b0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset mdu_out", mdu_out, 32'd0);
    mdu_op = 4'd0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed cases with literal expectations.
    issue(4'd1, 32'hFFFF_FFFE, 32'd3, 0, 4'd0, 32'd0, "mult_neg");
    check("mult_neg lit", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    issue(4'd4, 32'd100, 32'd7, 0, 4'd0, 32'd0, "divu");
    check("divu lit", {hi, lo}, {32'd2, 32'd14});
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 0, 4'd0, 32'd0, "div_neg");
    check("div_neg lit", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    issue(4'd3, 32'd5, 32'd0, 0, 4'd0, 32'd0, "div_zero");
    check("div_zero lit", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    issue(4'd4, 32'd9, 32'd0, 0, 4'd0, 32'd0, "divu_zero");
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 4'd0, 32'd0, "div_ovf");
    check("div_ovf lit", {hi, lo}, {32'd0, 32'h8000_0000});
    issue(4'd7, 32'h1234, 32'd0, 0, 4'd0, 32'd0, "mthi");
    issue(4'd1, 32'd2, 32'd3, 2, 4'd5, 32'd0, "mult_mfhi");
    check("mult_mfhi lit", {hi, lo}, {32'd0, 32'd6});
    issue(4'd1, 32'd2, 32'd3, 3, 4'd1, 32'd7, "mult_restart");
    issue(4'd4, 32'd50, 32'd5, 4, 4'd8, 32'h99, "divu_mtlo");

    // MADDU with carry from LO into HI.
    issue(4'd7, 32'd0, 32'd0, 0, 4'd0, 32'd0, "mthi0");
    issue(4'd8, 32'hFFFF_FFFF, 32'd0, 0, 4'd0, 32'd0, "mtlo");
    issue(4'd10, 32'd1, 32'd1, 0, 4'd0, 32'd0, "maddu");
`ifdef MDU_MADD_EN
    check("maddu lit", {hi, lo}, {32'd1, 32'd0});
`else
    check("maddu lit", {hi, lo}, {32'd0, 32'hFFFF_FFFF});
`endif

    // Async reset in RUN with cnt=3: everything clears and stays clear.
    issue(4'd7, 32'h55, 32'd0, 0, 4'd0, 32'd0, "mthi55");
    start = 1'b1; mdu_op = 4'd1; rs_val = 32'd2; rt_val = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; mdu_op = 4'd0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("abort later", {hi, lo}, 64'd0);
    // A start on the first edge after deassertion must be accepted.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    issue(4'd2, 32'd5, 32'd5, 0, 4'd0, 32'd0, "post_reset");
    check("post_reset lit", {hi, lo}, 64'd25);

    // Randomized sequence against the model.
    for (int i = 0; i < 60; i++) begin
      op  = 4'($urandom_range(0, 15));
      a   = rnd_opnd();
      b   = rnd_opnd();
      ic  = 0;
      iop = 4'($urandom_range(0, 15));
      if (exp_busy(op) > 0 && $urandom_range(0, 1) == 1)
        ic = $urandom_range(1, exp_busy(op) - 1);
      issue(op, a, b, ic, iop, $urandom, $sformatf("rnd%0d op%0d", i, op));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
